tx_serial_arbitro: RTL
======================

TX_SERIAL_ARBITRO -- requirements
Module: tx_serial_arbitro

Interface
REQ-001 SHALL have parameter INTERVALO, default 434: number of guard clock cycles after each character (one bit time at 115200 bauds, 50 MHz); legal range 1..511.
REQ-002 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req0  input  1  requester 0 asks to send one character; held high until ack0.
REQ-005 SHALL have port dado0  input  7  requester 0 ASCII character; stable while req0 is high.
REQ-006 SHALL have port req1  input  1  requester 1 request; same rules as req0.
REQ-007 SHALL have port dado1  input  7  requester 1 ASCII character.
REQ-008 SHALL have port ack0  output  1  one-cycle pulse: dado0 latched, so req0 may drop or change.
REQ-009 SHALL have port ack1  output  1  one-cycle pulse: dado1 latched.
REQ-010 SHALL have port tx_partida  output  1  one-cycle start pulse to the serial transmitter.
REQ-011 SHALL have port tx_dados  output  7  character to the transmitter; registered; stable from CARREGA until the next grant.
REQ-012 SHALL have port tx_pronto  input  1  end-of-character indication from the transmitter.
REQ-013 SHALL have port ocupado  output  1  high in every state except INICIAL and ESPERA.
REQ-014 SHALL have port db_vez  output  1  current priority pointer (requester favoured on a tie).
REQ-015 SHALL have port db_estado  output  4  current state code.

Function
REQ-016 SHALL be a Moore FSM with states INICIAL=0, ESPERA=1, CARREGA=2, PARTIDA=3, TRANSMITE=4, INTERVALO=5; codes 6..15 SHALL go to INICIAL on the next cycle.
REQ-017 INICIAL SHALL go to ESPERA unconditionally.
REQ-018 ESPERA with no req high SHALL stay in ESPERA; with exactly one req high, it SHALL grant that requester; with both high, it SHALL grant the requester named by db_vez; any grant SHALL go to CARREGA.
REQ-019 On a grant, tx_dados SHALL load the granted dado at the same edge, and db_vez SHALL change to the non-granted requester.
REQ-020 CARREGA SHALL assert ack of the granted requester only, for exactly one cycle, then go to PARTIDA.
REQ-021 PARTIDA SHALL assert tx_partida for exactly one cycle, then go to TRANSMITE.
REQ-022 TRANSMITE SHALL hold until tx_pronto=1, then go to INTERVALO.
REQ-023 tx_pronto SHALL be ignored in every state other than TRANSMITE.
REQ-024 INTERVALO SHALL last exactly INTERVALO cycles, then go to ESPERA; the counter SHALL be cleared on entry.
REQ-025 Latency: a req first sampled high in ESPERA at edge k SHALL give ack at cycle k+1 and tx_partida at cycle k+2.
REQ-026 req and dado changes outside ESPERA SHALL NOT affect the transfer in progress; the grant decision SHALL be made only in ESPERA.
REQ-027 A req still high after its ack SHALL be treated as a new request at the next ESPERA.
REQ-028 Under continuous contention, grants SHALL strictly alternate 0,1,0,1.

Reset
REQ-029 Reset SHALL force INICIAL, db_estado=0, ack0=ack1=0, tx_partida=0, tx_dados=0, ocupado=0, db_vez=0 and a cleared interval counter, at the next edge, in any state.
REQ-030 Reset during TRANSMITE or INTERVALO SHALL abandon the character with no ack and no further tx_partida; the transmitter shares the same reset.

Structure
REQ-031 State codes SHALL be defined in a shared header/package that the FSM and the bench both include.
REQ-032 The guard timer SHALL be the existing contador_m instance with M=INTERVALO and N=9; zera_s SHALL be asserted outside INTERVALO and fim SHALL end the state.
REQ-033 The design SHALL use a single FSM module plus the contador_m instance, with no other sub-modules.

Verification (INTERVALO=4)
REQ-034 Bench SHALL check: reset, then req0=1 with dado0=7'h41 -> ack0 one cycle later, tx_partida the cycle after, tx_dados=7'h41, db_vez=1.
REQ-035 Bench SHALL check: req0=req1=1 held with dado0=7'h30 and dado1=7'h31, and tx_pronto pulsed 10 cycles after each tx_partida -> tx_dados sequence 30,31,30,31 and alternating acks.
REQ-036 Bench SHALL check: tx_pronto pulse -> exactly 4 INTERVALO cycles, then ESPERA; a tx_pronto pulse during INTERVALO or ESPERA has no effect.
REQ-037 Bench SHALL check: dado0 changed to 7'h5A during TRANSMITE -> tx_dados stays 7'h41.
REQ-038 Bench SHALL check: reset asserted in TRANSMITE -> next cycle db_estado=0 and all outputs at reset values; no ack until a new request arrives.

Source files
------------

// File: rtl/tx_serial_arbitro_pkg.sv
// Purpose: shared state encoding and sizes for the serial-transmit arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package tx_serial_arbitro_pkg;

  // State codes are visible on db_estado, so the numeric values are fixed.
  typedef enum logic [3:0] {
    S_INICIAL   = 4'd0,
    S_ESPERA    = 4'd1,
    S_CARREGA   = 4'd2,
    S_PARTIDA   = 4'd3,
    S_TRANSMITE = 4'd4,
    S_INTERVALO = 4'd5
  } estado_t;

  localparam int DADO_W  = 7;  // ASCII character width
  localparam int CONT_W  = 9;  // guard counter width, enough for 511 cycles

endpackage

// File: rtl/contador_m.sv
// Purpose: modulo-M up counter with synchronous clear; fim flags the last count.
// Latency: fim is combinational from the registered count.
// Backpressure: none; counts only while conta is high.
//   clock  : rising-edge clock
//   zera_s : synchronous clear (wins over conta)
//   conta  : count enable
//   fim    : high while the count equals M-1
module contador_m #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic clock,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  logic [N-1:0] q;

  always_ff @(posedge clock) begin
    if (zera_s) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == ULTIMO) ? '0 : q + 1'b1;
    end
  end

  assign fim = (q == ULTIMO);

endmodule

// File: rtl/tx_serial_arbitro.sv
// Purpose: two-requester round-robin arbiter feeding one serial transmitter.
// Latency: req seen in ESPERA at edge k -> ack at k+1, tx_partida at k+2.
// Backpressure: requesters hold req until ack; a new grant waits for
//   tx_pronto plus INTERVALO guard cycles.
//   req0/dado0, req1/dado1 : requests and their characters
//   ack0/ack1              : one-cycle "character latched" pulses
//   tx_partida/tx_dados    : start pulse and character to the transmitter
//   tx_pronto              : transmitter finished the character
//   ocupado, db_vez, db_estado : busy flag, priority pointer, state code
module tx_serial_arbitro
  import tx_serial_arbitro_pkg::*;
#(
  parameter int INTERVALO = 434
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [DADO_W-1:0] dado0,
  input  logic              req1,
  input  logic [DADO_W-1:0] dado1,
  output logic              ack0,
  output logic              ack1,
  output logic              tx_partida,
  output logic [DADO_W-1:0] tx_dados,
  input  logic              tx_pronto,
  output logic              ocupado,
  output logic              db_vez,
  output logic [3:0]        db_estado
);

  estado_t estado;
  logic    escolha;   // requester that wins if a grant happens this cycle
  logic    fim;
  logic    zera_s;
  logic    conta;

  // A lone request wins outright; a tie goes to the requester db_vez names.
  assign escolha = (req0 && req1) ? db_vez : req1;

  // Counter starts from zero on every entry to the guard state; reset clears
  // it at the same edge as the FSM.
  assign zera_s = reset || (estado != S_INTERVALO);
  assign conta  = (estado == S_INTERVALO);

  contador_m #(
    .M (INTERVALO),
    .N (CONT_W)
  ) u_guarda (
    .clock  (clock),
    .zera_s (zera_s),
    .conta  (conta),
    .fim    (fim)
  );

  // Outputs are registered and set on the transition into the state that
  // owns them, so each is a clean function of the current state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= S_INICIAL;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      tx_partida <= 1'b0;
      tx_dados   <= '0;
      ocupado    <= 1'b0;
      db_vez     <= 1'b0;
    end else begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      tx_partida <= 1'b0;
      case (estado)
        S_INICIAL: begin
          estado  <= S_ESPERA;
          ocupado <= 1'b0;
        end
        S_ESPERA: begin
          if (req0 || req1) begin
            estado   <= S_CARREGA;
            ocupado  <= 1'b1;
            tx_dados <= escolha ? dado1 : dado0;
            db_vez   <= ~escolha;
            ack0     <= ~escolha;
            ack1     <= escolha;
          end else begin
            ocupado <= 1'b0;
          end
        end
        S_CARREGA: begin
          estado     <= S_PARTIDA;
          tx_partida <= 1'b1;
        end
        S_PARTIDA: begin
          estado <= S_TRANSMITE;
        end
        S_TRANSMITE: begin
          if (tx_pronto) begin
            estado <= S_INTERVALO;
          end
        end
        S_INTERVALO: begin
          if (fim) begin
            estado  <= S_ESPERA;
            ocupado <= 1'b0;
          end
        end
        default: begin
          estado  <= S_INICIAL;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign db_estado = estado;

endmodule
